// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its issue controller: opcodes, legality check,
// and the issue FSM state encoding.
package alu_pkg;

   localparam logic [3:0] OP_ADD = 4'h0;
   localparam logic [3:0] OP_SUB = 4'h1;
   localparam logic [3:0] OP_AND = 4'h2;
   localparam logic [3:0] OP_OR  = 4'h3;
   localparam logic [3:0] OP_XOR = 4'h4;
   localparam logic [3:0] OP_EQ  = 4'h5;
   localparam logic [3:0] OP_GT  = 4'h6;
   localparam logic [3:0] OP_SHL = 4'h7;
   localparam logic [3:0] OP_SHR = 4'h8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      DONE = 2'd2
   } state_t;

   // Legal opcodes form the contiguous range OP_ADD..OP_SHR.
   function automatic logic is_legal_op(input logic [3:0] op);
      return (op <= OP_SHR);
   endfunction

endpackage

// File: rtl/alu_regfile.sv
// NUM_REGS x 8 general register file: one write port, two operand reads and one debug read,
// all reads combinational.
module alu_regfile #(
   parameter int unsigned NUM_REGS = 4,
   parameter int unsigned REG_AW   = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic [REG_AW-1:0] waddr,
   input  logic [7:0]        wdata,
   input  logic [REG_AW-1:0] raddr_a,
   output logic [7:0]        rdata_a,
   input  logic [REG_AW-1:0] raddr_b,
   output logic [7:0]        rdata_b,
   input  logic [REG_AW-1:0] raddr_d,
   output logic [7:0]        rdata_d
);

   logic [7:0] regs [NUM_REGS];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs[i] <= '0;
         end
      end else if (we) begin
         regs[waddr] <= wdata;
      end
   end

   assign rdata_a = regs[raddr_a];
   assign rdata_b = regs[raddr_b];
   assign rdata_d = regs[raddr_d];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue/writeback control around a combinational 8-bit ALU: registers operands and opcode,
// writes the result back to the register file and latches Zero/Carry.
module alu_issue_ctrl
   import alu_pkg::*;
#(
   parameter int unsigned NUM_REGS = 4,
   parameter int unsigned REG_AW   = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              instr_valid,
   output logic              instr_ready,
   input  logic [3:0]        instr_op,
   input  logic [REG_AW-1:0] instr_rd,
   input  logic [REG_AW-1:0] instr_rs1,
   input  logic [REG_AW-1:0] instr_rs2,
   input  logic              wr_en,
   input  logic [REG_AW-1:0] wr_addr,
   input  logic [7:0]        wr_data,
   input  logic [REG_AW-1:0] rd_addr,
   output logic [7:0]        rd_data,
   output logic [7:0]        alu_a,
   output logic [7:0]        alu_b,
   output logic [3:0]        alu_op,
   input  logic [7:0]        alu_result,
   input  logic              alu_zero,
   input  logic              alu_carry,
   output logic              done_valid,
   output logic [7:0]        done_result,
   output logic              done_err,
   output logic              flag_zero,
   output logic              flag_carry
);

   state_t            state_q, state_d;
   logic [REG_AW-1:0] rd_q;
   logic              err_q;
   logic [7:0]        alu_a_q, alu_b_q;
   logic [3:0]        alu_op_q;
   logic [7:0]        done_result_q;
   logic              flag_zero_q, flag_carry_q;

   logic              accept, legal;
   logic [7:0]        rf_a, rf_b, opnd_a, opnd_b;
   logic              rf_we;
   logic [REG_AW-1:0] rf_waddr;
   logic [7:0]        rf_wdata;

   assign accept = instr_valid && (state_q == IDLE);
   assign legal  = is_legal_op(instr_op);

   // Same-cycle external write is forwarded so the operand sees the new value.
   assign opnd_a = (wr_en && (wr_addr == instr_rs1)) ? wr_data : rf_a;
   assign opnd_b = (wr_en && (wr_addr == instr_rs2)) ? wr_data : rf_b;

   // Writeback owns the port in EXEC; external loads are only honoured in IDLE.
   assign rf_we    = (state_q == EXEC) || ((state_q == IDLE) && wr_en);
   assign rf_waddr = (state_q == EXEC) ? rd_q : wr_addr;
   assign rf_wdata = (state_q == EXEC) ? alu_result : wr_data;

   alu_regfile #(
      .NUM_REGS (NUM_REGS),
      .REG_AW   (REG_AW)
   ) u_regfile (
      .clk     (clk),
      .rst_n   (rst_n),
      .we      (rf_we),
      .waddr   (rf_waddr),
      .wdata   (rf_wdata),
      .raddr_a (instr_rs1),
      .rdata_a (rf_a),
      .raddr_b (instr_rs2),
      .rdata_b (rf_b),
      .raddr_d (rd_addr),
      .rdata_d (rd_data)
   );

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (accept) state_d = legal ? EXEC : DONE;
         EXEC:    state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         rd_q          <= '0;
         err_q         <= 1'b0;
         alu_a_q       <= '0;
         alu_b_q       <= '0;
         alu_op_q      <= '0;
         done_result_q <= '0;
         flag_zero_q   <= 1'b0;
         flag_carry_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            if (legal) begin
               alu_a_q  <= opnd_a;
               alu_b_q  <= opnd_b;
               alu_op_q <= instr_op;
               rd_q     <= instr_rd;
               err_q    <= 1'b0;
            end else begin
               err_q         <= 1'b1;
               done_result_q <= '0;
            end
         end
         if (state_q == EXEC) begin
            done_result_q <= alu_result;
            flag_zero_q   <= alu_zero;
            flag_carry_q  <= alu_carry;
         end
      end
   end

   assign instr_ready = (state_q == IDLE);
   assign done_valid  = (state_q == DONE);
   assign done_err    = (state_q == DONE) && err_q;
   assign done_result = done_result_q;
   assign alu_a       = alu_a_q;
   assign alu_b       = alu_b_q;
   assign alu_op      = alu_op_q;
   assign flag_zero   = flag_zero_q;
   assign flag_carry  = flag_carry_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl with a behavioural ALU closing the loop.
module tb_alu_issue_ctrl;
   import alu_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       instr_valid = 1'b0;
   logic       instr_ready;
   logic [3:0] instr_op = '0;
   logic [1:0] instr_rd = '0, instr_rs1 = '0, instr_rs2 = '0;
   logic       wr_en = 1'b0;
   logic [1:0] wr_addr = '0;
   logic [7:0] wr_data = '0;
   logic [1:0] rd_addr = '0;
   logic [7:0] rd_data;
   logic [7:0] alu_a, alu_b;
   logic [3:0] alu_op;
   logic [7:0] alu_result;
   logic       alu_zero, alu_carry;
   logic       done_valid, done_err, flag_zero, flag_carry;
   logic [7:0] done_result;

   typedef struct {
      logic [7:0] res;
      logic       err;
      int         acc;
      int         lat;
   } exp_t;

   exp_t q[$];
   int   pass_cnt = 0, total_cnt = 0;
   int   cyc = 0, n_acc = 0, n_done = 0;

   alu_issue_ctrl #(.NUM_REGS(4), .REG_AW(2)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .instr_op    (instr_op),
      .instr_rd    (instr_rd),
      .instr_rs1   (instr_rs1),
      .instr_rs2   (instr_rs2),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .rd_addr     (rd_addr),
      .rd_data     (rd_data),
      .alu_a       (alu_a),
      .alu_b       (alu_b),
      .alu_op      (alu_op),
      .alu_result  (alu_result),
      .alu_zero    (alu_zero),
      .alu_carry   (alu_carry),
      .done_valid  (done_valid),
      .done_result (done_result),
      .done_err    (done_err),
      .flag_zero   (flag_zero),
      .flag_carry  (flag_carry)
   );

   always #5 clk = ~clk;

   // Behavioural ALU; sub carry means borrow.
   always_comb begin
      logic [8:0] s;
      s = '0;
      alu_carry = 1'b0;
      case (alu_op)
         OP_ADD: begin s = {1'b0, alu_a} + {1'b0, alu_b}; alu_carry = s[8]; end
         OP_SUB: begin s = {1'b0, alu_a - alu_b}; alu_carry = (alu_a < alu_b); end
         OP_AND: s = {1'b0, alu_a & alu_b};
         OP_OR:  s = {1'b0, alu_a | alu_b};
         OP_XOR: s = {1'b0, alu_a ^ alu_b};
         OP_EQ:  s = {8'd0, alu_a == alu_b};
         OP_GT:  s = {8'd0, alu_a > alu_b};
         OP_SHL: begin s = {1'b0, alu_a << 1}; alu_carry = alu_a[7]; end
         OP_SHR: begin s = {1'b0, alu_a >> 1}; alu_carry = alu_a[0]; end
         default: s = '0;
      endcase
      alu_result = s[7:0];
      alu_zero   = (s[7:0] == 8'd0);
   end

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (rst_n && instr_valid && instr_ready) n_acc <= n_acc + 1;
   end

   task automatic chk(input string name, input int act, input int exp);
      total_cnt++;
      if (act == exp) pass_cnt++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   // Monitor: pops the scoreboard whenever a retirement is presented.
   always @(negedge clk) begin
      if (rst_n && done_valid) begin
         n_done++;
         if (q.size() == 0) begin
            chk("unexpected_done", 1, 0);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("done_result", done_result, e.res);
            chk("done_err", done_err, e.err);
            chk("done_latency", cyc - e.acc, e.lat);
         end
      end
   end

   task automatic load(input logic [1:0] a, input logic [7:0] d);
      wr_en = 1'b1; wr_addr = a; wr_data = d;
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   task automatic chk_reg(input string name, input logic [1:0] a, input logic [7:0] exp);
      rd_addr = a;
      #1;
      chk(name, rd_data, exp);
   endtask

   task automatic wait_idle();
      int n = 0;
      while (!instr_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!instr_ready) chk("idle_timeout", 0, 1);
   endtask

   // Presents one instruction, waits for acceptance, then checks ALU inputs one cycle later.
   task automatic issue(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                        input logic [1:0] rs2, input logic [7:0] exp_res, input logic push,
                        input int exp_wait, input logic [7:0] exp_a, input logic [7:0] exp_b,
                        input logic [3:0] exp_op);
      int   waits = 0;
      exp_t e;
      instr_valid = 1'b1; instr_op = op; instr_rd = rd; instr_rs1 = rs1; instr_rs2 = rs2;
      while (!instr_ready && waits < 20) begin
         @(negedge clk);
         waits++;
      end
      if (!instr_ready) begin
         chk("issue_timeout", 0, 1);
         instr_valid = 1'b0;
         return;
      end
      if (exp_wait >= 0) chk("ready_low_cycles", waits, exp_wait);
      if (push) begin
         e.res = exp_res;
         e.err = !is_legal_op(op);
         e.acc = cyc;
         e.lat = is_legal_op(op) ? 2 : 1;
         q.push_back(e);
      end
      @(negedge clk);
      instr_valid = 1'b0;
      wr_en = 1'b0;
      chk("alu_a", alu_a, exp_a);
      chk("alu_b", alu_b, exp_b);
      chk("alu_op", alu_op, exp_op);
   endtask

   initial begin
      int acc0;
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int acc0;
      @(negedge clk);
      chk("rst_ready", instr_ready, 1);
      chk("rst_done_valid", done_valid, 0);
      chk("rst_done_err", done_err, 0);
      chk("rst_alu_a", alu_a, 0);
      chk("rst_done_result", done_result, 0);
      chk("rst_flags", {flag_zero, flag_carry}, 0);
      chk_reg("rst_r2", 2'd2, 8'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Basic add
      load(2'd0, 8'd10);
      load(2'd1, 8'd5);
      issue(OP_ADD, 2'd2, 2'd0, 2'd1, 8'd15, 1'b1, 0, 8'd10, 8'd5, OP_ADD);
      wait_idle();
      chk_reg("add_r2", 2'd2, 8'd15);
      chk("add_flags", {flag_zero, flag_carry}, 0);

      // Carry out, then zero result
      load(2'd0, 8'd200);
      load(2'd1, 8'd100);
      issue(OP_ADD, 2'd3, 2'd0, 2'd1, 8'd44, 1'b1, 0, 8'd200, 8'd100, OP_ADD);
      wait_idle();
      chk_reg("carry_r3", 2'd3, 8'd44);
      chk("carry_flags", {flag_zero, flag_carry}, 2'b01);
      issue(OP_SUB, 2'd2, 2'd0, 2'd0, 8'd0, 1'b1, 0, 8'd200, 8'd200, OP_SUB);
      wait_idle();
      chk_reg("zero_r2", 2'd2, 8'd0);
      chk("zero_flags", {flag_zero, flag_carry}, 2'b10);

      // Illegal opcode: no writeback, ALU inputs hold
      issue(4'b1010, 2'd1, 2'd0, 2'd0, 8'd0, 1'b1, 0, 8'd200, 8'd200, OP_SUB);
      wait_idle();
      chk_reg("illegal_r1", 2'd1, 8'd100);
      chk("illegal_flags", {flag_zero, flag_carry}, 2'b10);

      // Second instruction held while busy: accepted once, after two not-ready cycles
      acc0 = n_acc;
      issue(OP_XOR, 2'd0, 2'd3, 2'd1, 8'd72, 1'b1, 0, 8'd44, 8'd100, OP_XOR);
      issue(OP_OR, 2'd1, 2'd0, 2'd3, 8'd108, 1'b1, 2, 8'd72, 8'd44, OP_OR);
      // External write during EXEC must be ignored
      wr_en = 1'b1; wr_addr = 2'd0; wr_data = 8'd99;
      @(negedge clk);
      wr_en = 1'b0;
      wait_idle();
      chk("accept_count", n_acc - acc0, 2);
      chk_reg("exec_wr_ignored_r0", 2'd0, 8'd72);
      chk_reg("or_r1", 2'd1, 8'd108);

      // Bypass of same-cycle external write into both operands
      wr_en = 1'b1; wr_addr = 2'd1; wr_data = 8'd7;
      issue(OP_SUB, 2'd2, 2'd1, 2'd1, 8'd0, 1'b1, 0, 8'd7, 8'd7, OP_SUB);
      wait_idle();
      chk_reg("bypass_r1", 2'd1, 8'd7);
      chk_reg("bypass_r2", 2'd2, 8'd0);
      chk("bypass_flags", {flag_zero, flag_carry}, 2'b10);

      // Reset during EXEC drops the instruction
      issue(OP_ADD, 2'd3, 2'd0, 2'd1, 8'd0, 1'b0, 0, 8'd72, 8'd7, OP_ADD);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_alu_a", alu_a, 0);
      chk("mid_rst_alu_b", alu_b, 0);
      chk("mid_rst_alu_op", alu_op, 0);
      chk("mid_rst_done_valid", done_valid, 0);
      chk("mid_rst_flags", {flag_zero, flag_carry}, 0);
      chk("mid_rst_ready", instr_ready, 1);
      chk_reg("mid_rst_r3", 2'd3, 8'd0);
      @(negedge clk);
      chk("mid_rst_no_done", done_valid, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_ready", instr_ready, 1);
      chk_reg("post_rst_r0", 2'd0, 8'd0);
      load(2'd0, 8'd3);
      load(2'd1, 8'd4);
      issue(OP_ADD, 2'd3, 2'd0, 2'd1, 8'd7, 1'b1, 0, 8'd3, 8'd4, OP_ADD);
      wait_idle();
      chk_reg("post_rst_r3", 2'd3, 8'd7);
      @(negedge clk);

      chk("done_count", n_done, 8);
      chk("scoreboard_empty", q.size(), 0);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
